// File: rtl/mem_reader_pkg.sv
// Shared encodings and default widths for the result-memory unload path.
package mem_reader_pkg;

   localparam int unsigned NAWIDTH_DEFAULT = 2;
   localparam int unsigned NDWIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FETCH = 2'b01,
      SEND  = 2'b10,
      HALT  = 2'b11
   } state_e;

endpackage

// File: rtl/mem_reader_mem.sv
// Synchronous single-port memory: registered read, storage itself is never reset.
module mem
   import mem_reader_pkg::*;
#(
   parameter int unsigned Nawidth = NAWIDTH_DEFAULT,
   parameter int unsigned Ndwidth = NDWIDTH_DEFAULT
) (
   input  logic               clock,
   input  logic               Reset,
   input  logic               we,
   input  logic               re,
   input  logic [Nawidth-1:0] addr,
   input  logic [Ndwidth-1:0] din,
   output logic [Ndwidth-1:0] dout
);

   localparam int unsigned Depth = 2**Nawidth;

   logic [Ndwidth-1:0] store [Depth];

   always_ff @(posedge clock) begin
      if (we) begin
         store[addr] <= din;
      end
   end

   // Read register holds its last word when idle so the output never goes unknown.
   always_ff @(posedge clock or posedge Reset) begin
      if (Reset) begin
         dout <= '0;
      end else if (re) begin
         dout <= store[addr];
      end
   end

endmodule

// File: rtl/mem_reader.sv
// Streams the whole result memory out with a Valid/Ready handshake, one word per two cycles.
module mem_reader
   import mem_reader_pkg::*;
#(
   parameter int unsigned Nawidth = NAWIDTH_DEFAULT,
   parameter int unsigned Ndwidth = NDWIDTH_DEFAULT
) (
   input  logic               clock,
   input  logic               Reset,
   input  logic               Init,
   input  logic               Start,
   input  logic               WEIn,
   input  logic [Nawidth-1:0] AddrIn,
   input  logic [Ndwidth-1:0] DataIn,
   output logic [Ndwidth-1:0] DataOut,
   output logic               Valid,
   input  logic               Ready,
   output logic               Last,
   output logic               Busy,
   output logic               Done
);

   localparam logic [Nawidth-1:0] AddrLast = '1;

   state_e             state_q;
   state_e             state_d;
   logic [Nawidth-1:0] addr_r;
   logic [Nawidth-1:0] addr_d;
   logic               busy_c;
   logic               mem_we_c;
   logic [Nawidth-1:0] mem_addr_c;

   // Producer owns the memory port while idle or halted; the read counter owns it otherwise.
   assign busy_c     = (state_q == FETCH) || (state_q == SEND);
   assign mem_addr_c = busy_c ? addr_r : AddrIn;
   assign mem_we_c   = WEIn && !Init && !busy_c;

   mem #(
      .Nawidth (Nawidth),
      .Ndwidth (Ndwidth)
   ) u_mem (
      .clock (clock),
      .Reset (Reset),
      .we    (mem_we_c),
      .re    (busy_c),
      .addr  (mem_addr_c),
      .din   (DataIn),
      .dout  (DataOut)
   );

   always_ff @(posedge clock or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         addr_r  <= '0;
         Valid   <= 1'b0;
         Last    <= 1'b0;
         Busy    <= 1'b0;
         Done    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_r  <= addr_d;
         Valid   <= (state_d == SEND);
         Last    <= (state_d == SEND) && (addr_d == AddrLast);
         Busy    <= (state_d == FETCH) || (state_d == SEND);
         Done    <= (state_d == HALT);
      end
   end

   // Init overrides every other input; a word leaves SEND only on Ready.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_r;
      if (Init) begin
         state_d = IDLE;
         addr_d  = '0;
      end else begin
         case (state_q)
            IDLE, HALT: begin
               if (Start) begin
                  state_d = FETCH;
                  addr_d  = '0;
               end
            end
            FETCH: begin
               state_d = SEND;
            end
            SEND: begin
               if (Ready) begin
                  if (addr_r == AddrLast) begin
                     state_d = HALT;
                     addr_d  = '0;
                  end else begin
                     state_d = FETCH;
                     addr_d  = addr_r + Nawidth'(1);
                  end
               end
            end
            default: begin
               state_d = IDLE;
               addr_d  = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_reader.sv
// Directed bench for mem_reader with a word-stream reference model checked every cycle.
module tb_mem_reader;

   localparam int unsigned AW     = 2;
   localparam int unsigned DW     = 8;
   localparam int unsigned NWORDS = 4;

   logic          clock = 1'b0;
   logic          Reset;
   logic          Init;
   logic          Start;
   logic          WEIn;
   logic [AW-1:0] AddrIn;
   logic [DW-1:0] DataIn;
   logic [DW-1:0] DataOut;
   logic          Valid;
   logic          Ready;
   logic          Last;
   logic          Busy;
   logic          Done;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   mem_reader #(.Nawidth(AW), .Ndwidth(DW)) dut (
      .clock   (clock),
      .Reset   (Reset),
      .Init    (Init),
      .Start   (Start),
      .WEIn    (WEIn),
      .AddrIn  (AddrIn),
      .DataIn  (DataIn),
      .DataOut (DataOut),
      .Valid   (Valid),
      .Ready   (Ready),
      .Last    (Last),
      .Busy    (Busy),
      .Done    (Done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: a pass delivers words 0..N-1 in order, each visible after one fetch cycle.
   logic [DW-1:0] m_mem [NWORDS];
   bit m_active = 0;
   bit m_done   = 0;
   int m_idx    = 0;
   int m_wait   = 0;

   always @(posedge clock or posedge Reset) begin
      if (Reset || Init) begin
         m_active = 0;
         m_done   = 0;
         m_idx    = 0;
         m_wait   = 0;
      end else if (m_active) begin
         if (m_wait > 0) begin
            m_wait--;
         end else if (Ready) begin
            if (m_idx == NWORDS - 1) begin
               m_active = 0;
               m_done   = 1;
               m_idx    = 0;
            end else begin
               m_idx++;
               m_wait = 1;
            end
         end
      end else begin
         if (WEIn) m_mem[AddrIn] = DataIn;
         if (Start) begin
            m_active = 1;
            m_done   = 0;
            m_idx    = 0;
            m_wait   = 1;
         end
      end
   end

   int cyc = 0;
   always @(posedge clock) cyc++;

   int beat_data[$];
   int beat_cyc[$];
   int beat_last[$];
   int stall_cnt = 0;
   bit cmp_en = 0;

   // Per-cycle comparison against the model, plus a log of accepted beats.
   always @(negedge clock) begin
      bit exp_valid;
      if (cmp_en) begin
         exp_valid = m_active && (m_wait == 0);
         if (Reset) begin
            chk("rst_valid", Valid, 0);
            chk("rst_busy", Busy, 0);
            chk("rst_done", Done, 0);
            chk("rst_last", Last, 0);
            chk("rst_data", DataOut, 0);
         end else begin
            chk("valid", Valid, exp_valid);
            chk("busy", Busy, m_active);
            chk("done", Done, m_done);
            chk("last", Last, exp_valid && (m_idx == NWORDS - 1));
            chk("data_known", $isunknown(DataOut), 0);
            if (exp_valid) chk("data", DataOut, m_mem[m_idx]);
            if (Valid && Ready) begin
               beat_data.push_back(int'(DataOut));
               beat_cyc.push_back(cyc);
               beat_last.push_back(int'(Last));
            end
            if (Valid && !Ready) stall_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // mode: 0 plain, 1 stall 3 on 0x22, 2 write during word 0, 3 Init on 0x33, 4 Start during SEND
   task automatic run_pass(input int mode, output bit finished);
      int  stall_left;
      bit  wrote;
      stall_left = 3;
      wrote      = 0;
      finished   = 0;
      beat_data.delete();
      beat_cyc.delete();
      beat_last.delete();
      stall_cnt = 0;
      Ready = 1'b1;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (Done) begin
            finished = 1;
            break;
         end
         Ready = 1'b1;
         WEIn  = 1'b0;
         Start = 1'b0;
         if (mode == 1 && Valid && DataOut == 8'h22 && stall_left > 0) begin
            Ready = 1'b0;
            stall_left--;
         end
         if (mode == 2 && Valid && DataOut == 8'h11 && !wrote) begin
            WEIn   = 1'b1;
            AddrIn = 2'd2;
            DataIn = 8'hAA;
            wrote  = 1;
         end
         if (mode == 3 && Valid && DataOut == 8'h33) begin
            Init = 1'b1;
            tick();
            Init = 1'b0;
            chk("init_valid", Valid, 0);
            chk("init_busy", Busy, 0);
            chk("init_done", Done, 0);
            finished = 1;
            break;
         end
         if (mode == 4) Start = Valid;
         tick();
      end
      Ready = 1'b1;
      WEIn  = 1'b0;
      Start = 1'b0;
   endtask

   task automatic check_stream(input string tag, input int first_gap);
      int exp_d [NWORDS];
      exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
      chk({tag, "_beats"}, beat_data.size(), NWORDS);
      for (int i = 0; i < NWORDS; i++) begin
         if (i < beat_data.size()) begin
            chk({tag, "_word"}, beat_data[i], exp_d[i]);
            chk({tag, "_lastflag"}, beat_last[i], (i == NWORDS - 1) ? 1 : 0);
            if (i > 0) chk({tag, "_gap"}, beat_cyc[i] - beat_cyc[i-1], (i == 1) ? first_gap : 2);
         end
      end
   endtask

   initial begin
      bit fin;
      logic [DW-1:0] init_words [NWORDS];
      init_words = '{8'h11, 8'h22, 8'h33, 8'h44};
      Reset  = 1'b1;
      Init   = 1'b0;
      Start  = 1'b0;
      WEIn   = 1'b0;
      Ready  = 1'b0;
      AddrIn = '0;
      DataIn = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("reset_valid", Valid, 0);
      chk("reset_last", Last, 0);
      chk("reset_busy", Busy, 0);
      chk("reset_done", Done, 0);
      chk("reset_data", DataOut, 0);
      cmp_en = 1;
      Reset  = 1'b0;
      tick();

      for (int i = 0; i < NWORDS; i++) begin
         WEIn   = 1'b1;
         AddrIn = AW'(i);
         DataIn = init_words[i];
         tick();
      end
      WEIn = 1'b0;

      run_pass(0, fin);
      chk("plain_finished", fin, 1);
      check_stream("plain", 2);
      chk("plain_done_after", Done, 1);

      run_pass(0, fin);
      chk("replay_finished", fin, 1);
      check_stream("replay", 2);

      run_pass(1, fin);
      chk("stall_finished", fin, 1);
      check_stream("stall", 5);
      chk("stall_samples", stall_cnt, 3);

      run_pass(2, fin);
      chk("wr_send_finished", fin, 1);
      check_stream("wr_send", 2);
      run_pass(0, fin);
      check_stream("wr_send_after", 2);

      run_pass(3, fin);
      chk("init_taken", fin, 1);
      chk("init_beats", beat_data.size() >= 2 ? beat_data[1] : 0, 8'h22);
      run_pass(0, fin);
      chk("after_init_finished", fin, 1);
      check_stream("after_init", 2);

      run_pass(4, fin);
      chk("start_send_finished", fin, 1);
      check_stream("start_send", 2);

      tick();
      Start = 1'b1;
      tick();
      Start = 1'b0;
      chk("fetch_busy", Busy, 1);
      #2;
      Reset = 1'b1;
      #1;
      chk("async_busy", Busy, 0);
      chk("async_valid", Valid, 0);
      chk("async_data", DataOut, 0);
      @(negedge clock);
      #1;
      Reset = 1'b0;
      tick();
      run_pass(0, fin);
      chk("post_reset_finished", fin, 1);
      check_stream("post_reset", 2);

      repeat (2) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_reader.md
MEM_READER -- requirements
Module: mem_reader

Interface
REQ-001 Parameter Nawidth, default 2, address width; memory depth is 2**Nawidth words.
REQ-002 Parameter Ndwidth, default 8, data width per word.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Init  input  1  synchronous clear; returns the block to IDLE.
REQ-006 Start  input  1  begins one unload pass from address 0.
REQ-007 WEIn  input  1  producer write enable for the result memory.
REQ-008 AddrIn  input  Nawidth  producer write address.
REQ-009 DataIn  input  Ndwidth  producer write data.
REQ-010 DataOut  output  Ndwidth  streamed word.
REQ-011 Valid  output  1  DataOut holds a word to be consumed.
REQ-012 Ready  input  1  consumer accepts DataOut this cycle.
REQ-013 Last  output  1  current word is at address 2**Nawidth-1.
REQ-014 Busy  output  1  high in FETCH or SEND.
REQ-015 Done  output  1  high in HALT.

Function
REQ-016 The block SHALL use a 4-state FSM: IDLE, FETCH, SEND, HALT.
REQ-017 In IDLE and HALT, the memory address SHALL be AddrIn; a write SHALL occur on every edge with WEIn=1; in FETCH and SEND, WEIn SHALL be ignored.
REQ-018 IDLE or HALT with Start=1 and Init=0 SHALL go to FETCH with read counter AddrR=0.
REQ-019 Start in FETCH or SEND SHALL be ignored.
REQ-020 In FETCH and SEND, the memory address SHALL be AddrR. Read latency is one cycle.
REQ-021 FETCH SHALL last exactly one cycle and then go to SEND.
REQ-022 In SEND, Valid=1 and DataOut = mem[AddrR].
REQ-023 DataOut and Valid SHALL stay stable while Ready=0 in SEND; there is no timeout.
REQ-024 In SEND with Ready=1 and AddrR < 2**Nawidth-1: AddrR increments and the FSM goes to FETCH.
REQ-025 In SEND with Ready=1 and AddrR = 2**Nawidth-1: AddrR wraps to 0 and the FSM goes to HALT.
REQ-026 Throughput SHALL be one word per two cycles when Ready is held at 1.
REQ-027 Last SHALL equal Valid AND (AddrR = 2**Nawidth-1).
REQ-028 Valid SHALL be 0 outside SEND; DataOut outside SEND is don't-care but not X after reset.
REQ-029 Init=1 SHALL take priority over Start, Ready and WEIn: next state IDLE, AddrR=0, no memory write.
REQ-030 Memory contents SHALL persist across Init, Start and HALT; a second Start SHALL replay the same data.

Reset
REQ-031 Reset=1 SHALL immediately force state IDLE and AddrR=0, independent of clock.
REQ-032 Reset values: Valid=0, Last=0, Busy=0, Done=0, DataOut=0.
REQ-033 Memory contents SHALL NOT be reset.
REQ-034 Reset during SEND SHALL drop Valid in the same cycle; no partial handshake completes.

Structure
REQ-035 The shared package SHALL hold the state encodings (IDLE=2'b00, FETCH=2'b01, SEND=2'b10, HALT=2'b11) and the default widths.
REQ-036 The storage SHALL be one instance of the existing synchronous single-port memory module mem, with Nawidth and Ndwidth passed through.
REQ-037 FSM, read counter and address mux SHALL be implemented in mem_reader itself.

Verification
REQ-038 Write 0x11,0x22,0x33,0x44 to addresses 0..3, pulse Start, hold Ready=1 -> words 0x11,0x22,0x33,0x44 each with Valid high for one cycle, two cycles apart; Last only with 0x44; Done=1 afterwards.
REQ-039 Same load, Ready=0 for 3 cycles during 0x22 -> DataOut=0x22 and Valid=1 held for all 3 cycles; the sequence then continues unchanged.
REQ-040 WEIn=1 with AddrIn=2 and DataIn=0xAA during SEND of word 0 -> stream still delivers 0x33 at address 2.
REQ-041 Init pulsed while 0x33 is Valid -> Valid=0 and state IDLE next cycle; Start then replays from 0x11.
REQ-042 Reset asserted between clock edges in FETCH -> Busy=0 and Valid=0 immediately; after release, Start replays 0x11..0x44 with memory intact.
REQ-043 Start in HALT -> full second pass with identical data; Start during SEND -> no effect on order or timing.
